if_id_hazard: RTL and testbench

IF_ID_HAZARD -- requirements
Module: if_id_hazard

---
 rtl/if_id_hazard_if.sv | 25 ++
 rtl/if_id_hazard.sv | 80 ++++++++
 tb/tb_if_id_hazard.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/if_id_hazard_if.sv
// Fetch/decode pipeline bundle: fetch-side inputs, ID/EX hazard sources and
// the IF/ID register outputs with stall/flush controls.
interface if_id_hazard_if;
    logic [63:0] PC_in;
    logic [31:0] instruction_in;
    logic        id_ex_MemRead;
    logic [4:0]  id_ex_write_register;
    logic        branch_taken;
    logic [63:0] PC_out;
    logic [31:0] instruction_out;
    logic        valid_out;
    logic        pc_wren;
    logic        id_ex_bubble;
    logic [15:0] stall_count;

    modport master (
        output PC_in, instruction_in, id_ex_MemRead, id_ex_write_register, branch_taken,
        input  PC_out, instruction_out, valid_out, pc_wren, id_ex_bubble, stall_count
    );

    modport slave (
        input  PC_in, instruction_in, id_ex_MemRead, id_ex_write_register, branch_taken,
        output PC_out, instruction_out, valid_out, pc_wren, id_ex_bubble, stall_count
    );
endinterface

// File: rtl/if_id_hazard.sv
// IF/ID pipeline register with load-use stall detection, branch flush and a
// saturating stall counter.
module if_id_hazard #(
    parameter logic [15:0] STALL_CNT_RST = 16'h0000
) (
    input  logic           clock,
    input  logic           reset,
    if_id_hazard_if.slave  bus
);
    typedef enum logic {RUN, STALL} state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [15:0] cnt_q, cnt_d;

    logic [4:0]  rn, rm, rt;
    logic        src_match;
    logic        hazard;

    // Register fields are compared for every opcode; a spurious match only costs one bubble.
    always_comb begin
        rn        = instr_q[9:5];
        rm        = instr_q[20:16];
        rt        = instr_q[4:0];
        src_match = (bus.id_ex_write_register == rn) ||
                    (bus.id_ex_write_register == rm) ||
                    (bus.id_ex_write_register == rt);
        hazard    = valid_q && bus.id_ex_MemRead &&
                    (bus.id_ex_write_register != 5'd31) && src_match &&
                    (state_q == RUN) && !bus.branch_taken;
    end

    always_comb begin
        state_d          = RUN;
        pc_d             = bus.PC_in;
        instr_d          = bus.instruction_in;
        valid_d          = 1'b1;
        cnt_d            = cnt_q;
        bus.pc_wren      = 1'b1;
        bus.id_ex_bubble = 1'b0;
        if (bus.branch_taken) begin
            instr_d          = '0;
            valid_d          = 1'b0;
            bus.id_ex_bubble = 1'b1;
        end else if (hazard) begin
            pc_d             = pc_q;
            instr_d          = instr_q;
            valid_d          = valid_q;
            state_d          = STALL;
            bus.pc_wren      = 1'b0;
            bus.id_ex_bubble = 1'b1;
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= STALL_CNT_RST;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.PC_out          = pc_q;
    assign bus.instruction_out = instr_q;
    assign bus.valid_out       = valid_q;
    assign bus.stall_count     = cnt_q;
endmodule

// File: tb/tb_if_id_hazard.sv
// Directed bench for if_id_hazard: reset, load-use stalls, XZR exclusion,
// flush priority and counter saturation (second instance preloaded near max).
module tb_if_id_hazard;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    if_id_hazard_if bus ();
    if_id_hazard_if sbus ();

    if_id_hazard dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    if_id_hazard #(.STALL_CNT_RST(16'hFFFE)) u_sat (
        .clock (clock),
        .reset (reset),
        .bus   (sbus.slave)
    );

    localparam logic [31:0] ADD_X3_X2_X4 = 32'h8B040043;  // Rm=4 Rn=2 Rt=3
    localparam logic [31:0] ADD_X6_X5_X5 = 32'h8B0500A6;  // Rm=5 Rn=5 Rt=6
    localparam logic [31:0] ADD_X3_XZR   = 32'h8B0403E3;  // Rm=4 Rn=31 Rt=3
    localparam logic [31:0] INSN_NEXT    = 32'h91000421;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #20000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.PC_in = 64'h0;  bus.instruction_in = 32'h0;
        bus.id_ex_MemRead = 1'b0;  bus.id_ex_write_register = 5'd0;  bus.branch_taken = 1'b0;
        sbus.PC_in = 64'h0; sbus.instruction_in = 32'h0;
        sbus.id_ex_MemRead = 1'b0; sbus.id_ex_write_register = 5'd0; sbus.branch_taken = 1'b0;

        // reset asserted before any clock edge
        #3 reset = 1'b0;
        #1;
        chk("rst_pc",    bus.PC_out, 64'h0);
        chk("rst_instr", {32'h0, bus.instruction_out}, 64'h0);
        chk("rst_valid", {63'h0, bus.valid_out}, 64'h0);
        chk("rst_cnt",   {48'h0, bus.stall_count}, 64'h0);
        chk("rst_wren",  {63'h0, bus.pc_wren}, 64'h1);
        chk("rst_bub",   {63'h0, bus.id_ex_bubble}, 64'h0);
        bus.PC_in = 64'h4; bus.instruction_in = INSN_NEXT;
        tick();
        chk("rst_hold_valid", {63'h0, bus.valid_out}, 64'h0);
        #3 reset = 1'b1;
        tick();
        chk("rel_pc",    bus.PC_out, 64'h4);
        chk("rel_valid", {63'h0, bus.valid_out}, 64'h1);

        // load-use on Rn
        bus.PC_in = 64'h8; bus.instruction_in = ADD_X3_X2_X4;
        tick();
        chk("lu_load_instr", {32'h0, bus.instruction_out}, {32'h0, ADD_X3_X2_X4});
        bus.id_ex_MemRead = 1'b1; bus.id_ex_write_register = 5'd2;
        bus.PC_in = 64'hC; bus.instruction_in = ADD_X6_X5_X5;
        #1;
        chk("lu_wren", {63'h0, bus.pc_wren}, 64'h0);
        chk("lu_bub",  {63'h0, bus.id_ex_bubble}, 64'h1);
        tick();
        chk("lu_hold_pc",    bus.PC_out, 64'h8);
        chk("lu_hold_instr", {32'h0, bus.instruction_out}, {32'h0, ADD_X3_X2_X4});
        chk("lu_cnt",        {48'h0, bus.stall_count}, 64'd1);
        // still matching, but STALL never repeats
        chk("lu_no2_wren", {63'h0, bus.pc_wren}, 64'h1);
        chk("lu_no2_bub",  {63'h0, bus.id_ex_bubble}, 64'h0);
        tick();
        chk("lu_resume_pc",  bus.PC_out, 64'hC);
        chk("lu_resume_cnt", {48'h0, bus.stall_count}, 64'd1);

        // load-use on Rt field of decode instruction
        bus.id_ex_write_register = 5'd6; bus.PC_in = 64'h10; bus.instruction_in = ADD_X3_XZR;
        #1;
        chk("rt_wren", {63'h0, bus.pc_wren}, 64'h0);
        tick();
        chk("rt_cnt", {48'h0, bus.stall_count}, 64'd2);
        bus.id_ex_MemRead = 1'b0;
        #1;
        chk("nomem_wren", {63'h0, bus.pc_wren}, 64'h1);
        tick();
        chk("xzr_load", {32'h0, bus.instruction_out}, {32'h0, ADD_X3_XZR});

        // XZR destination never stalls
        bus.id_ex_MemRead = 1'b1; bus.id_ex_write_register = 5'd31;
        #1;
        chk("xzr_wren", {63'h0, bus.pc_wren}, 64'h1);
        chk("xzr_bub",  {63'h0, bus.id_ex_bubble}, 64'h0);

        // flush beats stall
        bus.id_ex_MemRead = 1'b0; bus.PC_in = 64'h14; bus.instruction_in = ADD_X3_X2_X4;
        tick();
        bus.id_ex_MemRead = 1'b1; bus.id_ex_write_register = 5'd2;
        bus.branch_taken = 1'b1; bus.PC_in = 64'h40; bus.instruction_in = INSN_NEXT;
        #1;
        chk("fb_wren", {63'h0, bus.pc_wren}, 64'h1);
        chk("fb_bub",  {63'h0, bus.id_ex_bubble}, 64'h1);
        tick();
        chk("fb_valid", {63'h0, bus.valid_out}, 64'h0);
        chk("fb_instr", {32'h0, bus.instruction_out}, 64'h0);
        chk("fb_pc",    bus.PC_out, 64'h40);
        chk("fb_cnt",   {48'h0, bus.stall_count}, 64'd2);
        bus.branch_taken = 1'b0;
        #1;
        chk("fb_novalid_bub", {63'h0, bus.id_ex_bubble}, 64'h0);

        // flush while in STALL
        bus.id_ex_MemRead = 1'b0; bus.PC_in = 64'h44; bus.instruction_in = ADD_X3_X2_X4;
        tick();
        bus.id_ex_MemRead = 1'b1;
        tick();
        chk("fs_cnt", {48'h0, bus.stall_count}, 64'd3);
        bus.branch_taken = 1'b1; bus.PC_in = 64'h80;
        #1;
        chk("fs_bub",  {63'h0, bus.id_ex_bubble}, 64'h1);
        chk("fs_wren", {63'h0, bus.pc_wren}, 64'h1);
        tick();
        chk("fs_valid", {63'h0, bus.valid_out}, 64'h0);
        bus.branch_taken = 1'b0; bus.id_ex_MemRead = 1'b0;
        bus.PC_in = 64'h84; bus.instruction_in = INSN_NEXT;
        tick();
        chk("fs_next_pc",    bus.PC_out, 64'h84);
        chk("fs_next_valid", {63'h0, bus.valid_out}, 64'h1);

        // reset mid-stall
        bus.instruction_in = ADD_X3_X2_X4;
        tick();
        bus.id_ex_MemRead = 1'b1; bus.id_ex_write_register = 5'd2;
        tick();
        reset = 1'b0;
        #1;
        chk("rs_cnt",   {48'h0, bus.stall_count}, 64'd0);
        chk("rs_valid", {63'h0, bus.valid_out}, 64'h0);
        chk("rs_wren",  {63'h0, bus.pc_wren}, 64'h1);
        #1 reset = 1'b1;
        bus.PC_in = 64'h90; bus.instruction_in = INSN_NEXT;
        tick();
        chk("rs_load_instr", {32'h0, bus.instruction_out}, {32'h0, INSN_NEXT});
        chk("rs_load_valid", {63'h0, bus.valid_out}, 64'h1);

        // saturation on the preloaded instance
        chk("sat_rst", {48'h0, sbus.stall_count}, 64'hFFFE);
        sbus.PC_in = 64'h8; sbus.instruction_in = ADD_X3_X2_X4;
        tick();
        sbus.id_ex_MemRead = 1'b1; sbus.id_ex_write_register = 5'd2;
        tick();
        chk("sat_first", {48'h0, sbus.stall_count}, 64'hFFFF);
        tick();
        #1;
        chk("sat_again_wren", {63'h0, sbus.pc_wren}, 64'h0);
        tick();
        chk("sat_hold", {48'h0, sbus.stall_count}, 64'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
